// File: rtl/datamem_dump_reader.sv
// Walks a range of data-memory words through the debug read port and
// streams each word out as four bytes, MSB first, on a valid/ready link.
module datamem_dump_reader #(
   parameter int NB_REG     = 32,
   parameter int NB_ADDR    = 16,
   parameter int RD_LATENCY = 1
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic               i_abort,
   input  logic [NB_ADDR-1:0] i_base_addr,
   input  logic [NB_ADDR-1:0] i_count,
   output logic [NB_ADDR-1:0] o_debug_datamem_addr,
   output logic               o_debug_datamem_re,
   input  logic [NB_REG-1:0]  i_debug_datamem_data,
   output logic [7:0]         o_tx_data,
   output logic               o_tx_valid,
   input  logic               i_tx_ready,
   output logic               o_busy,
   output logic               o_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_SEND,
      S_DONE
   } state_t;

   localparam logic [NB_ADDR-1:0] ONE     = NB_ADDR'(1);
   localparam logic [2:0]         LAT_END = 3'(RD_LATENCY - 1);

   state_t              state_q, state_d;
   logic [NB_ADDR-1:0]  addr_q, addr_d;
   logic [NB_ADDR-1:0]  remain_q, remain_d;
   logic [2:0]          lat_q, lat_d;
   logic [NB_REG-1:0]   shift_q, shift_d;
   logic [1:0]          idx_q, idx_d;
   logic                re_q, re_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      remain_d = remain_q;
      lat_d    = lat_q;
      shift_d  = shift_q;
      idx_d    = idx_q;
      unique case (state_q)
         S_IDLE: begin
            if (i_start) begin
               addr_d   = i_base_addr;
               remain_d = i_count;
               state_d  = (i_count == '0) ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            lat_d   = 3'd0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (lat_q == LAT_END) begin
               shift_d = i_debug_datamem_data;
               idx_d   = 2'd0;
               state_d = S_SEND;
            end else begin
               lat_d = lat_q + 3'd1;
            end
         end
         S_SEND: begin
            if (i_tx_ready) begin
               shift_d = {shift_q[NB_REG-9:0], 8'h00};
               idx_d   = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  remain_d = remain_q - ONE;
                  if (remain_q == ONE) begin
                     state_d = S_DONE;
                  end else begin
                     addr_d  = addr_q + ONE;
                     state_d = S_READ;
                  end
               end
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // abort wins over start and over a byte transfer; progress is frozen
      if (i_abort) begin
         state_d  = S_IDLE;
         addr_d   = addr_q;
         remain_d = remain_q;
         lat_d    = lat_q;
         shift_d  = shift_q;
         idx_d    = idx_q;
      end
      re_d   = (state_d == S_READ);
      busy_d = (state_d == S_READ) || (state_d == S_WAIT) ||
               (state_d == S_SEND);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         remain_q <= '0;
         lat_q    <= '0;
         shift_q  <= '0;
         idx_q    <= '0;
         re_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         remain_q <= remain_d;
         lat_q    <= lat_d;
         shift_q  <= shift_d;
         idx_q    <= idx_d;
         re_q     <= re_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign o_debug_datamem_addr = addr_q;
   assign o_debug_datamem_re   = re_q;
   assign o_busy               = busy_q;
   assign o_done               = done_q;
   assign o_tx_valid           = (state_q == S_SEND);
   assign o_tx_data            = shift_q[NB_REG-1:NB_REG-8];

endmodule
